// File: rtl/alu_if.sv
// alu_if: operand/funct bus into the MIPS R-type ALU
// and the registered result/overflow back out.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       funct;
  logic [WIDTH-1:0] INa;
  logic [WIDTH-1:0] INb;
  logic [WIDTH-1:0] OUT;
  logic             overflow;

  modport master (
    output funct,
    output INa,
    output INb,
    input  OUT,
    input  overflow
  );

  modport slave (
    input  funct,
    input  INa,
    input  INb,
    output OUT,
    output overflow
  );
endinterface

// File: rtl/alu.sv
// alu: 32-bit MIPS R-type ALU, one-cycle registered result.
// Define ALU_SHIFT_EN to build the shifter (sll/srl/sra + v forms).
module alu #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             lt_s;
  logic             lt_u;
  logic [5:0]       f;

  logic op_add, op_addu, op_sub, op_subu;
  logic op_and, op_or, op_xor, op_nor;
  logic op_slt, op_sltu;

  assign a    = bus.INa;
  assign b    = bus.INb;
  assign f    = bus.funct;
  assign sum  = a + b;
  assign dif  = a - b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  assign op_add  = f == 6'b100000;
  assign op_addu = f == 6'b100001;
  assign op_sub  = f == 6'b100010;
  assign op_subu = f == 6'b100011;
  assign op_and  = f == 6'b100100;
  assign op_or   = f == 6'b100101;
  assign op_xor  = f == 6'b100110;
  assign op_nor  = f == 6'b100111;
  assign op_slt  = f == 6'b101010;
  assign op_sltu = f == 6'b101011;

`ifdef ALU_SHIFT_EN
  logic [4:0]       shamt;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] sha;
  logic             op_sll, op_srl, op_sra;

  // Immediate and variable forms differ only in funct[2]
  assign op_sll = f == 6'b000000 || f == 6'b000100;
  assign op_srl = f == 6'b000010 || f == 6'b000110;
  assign op_sra = f == 6'b000011 || f == 6'b000111;
  assign shamt  = a[4:0];
  assign shl    = b << shamt;
  assign shr    = b >> shamt;
  assign sha    = $signed(b) >>> shamt;
`endif

  // Decode funct and select the result and overflow flag
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (1'b1)
      op_add: begin
        res = sum;
        ovf = (a[MSB] == b[MSB]) &&
              (sum[MSB] != a[MSB]);
      end
      op_addu: res = sum;
      op_sub: begin
        res = dif;
        ovf = (a[MSB] != b[MSB]) &&
              (dif[MSB] != a[MSB]);
      end
      op_subu: res = dif;
      op_and:  res = a & b;
      op_or:   res = a | b;
      op_xor:  res = a ^ b;
      op_nor:  res = ~(a | b);
      op_slt:  res = {{(WIDTH-1){1'b0}}, lt_s};
      op_sltu: res = {{(WIDTH-1){1'b0}}, lt_u};
`ifdef ALU_SHIFT_EN
      op_sll:  res = shl;
      op_srl:  res = shr;
      op_sra:  res = sha;
`endif
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

  // Register result; reset wins over the datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.OUT      <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.OUT      <= res;
      bus.overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for the registered MIPS ALU.
// Expectations follow ALU_SHIFT_EN the same way the design does.
module tb_alu;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [32:0] q[$];
  logic [32:0] prev;
  bit          have_prev;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag,
                       logic [32:0] got,
                       logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(
    logic [5:0] f, logic [31:0] a, logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint r;
    logic [31:0] o;
    logic v;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    o  = '0;
    v  = 1'b0;
    sh = int'(a[4:0]);
    r  = 0;
    case (f)
      6'h20: begin
        r = sa + sb;
        o = r[31:0];
        v = (r > 64'sd2147483647) ||
            (r < -64'sd2147483648);
      end
      6'h21: begin r = ua + ub; o = r[31:0]; end
      6'h22: begin
        r = sa - sb;
        o = r[31:0];
        v = (r > 64'sd2147483647) ||
            (r < -64'sd2147483648);
      end
      6'h23: begin r = ua - ub; o = r[31:0]; end
      6'h24: o = a & b;
      6'h25: o = a | b;
      6'h26: o = a ^ b;
      6'h27: o = ~(a | b);
      6'h2A: o = (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: o = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      6'h00, 6'h04: begin
        r = ub << sh; o = r[31:0];
      end
      6'h02, 6'h06: begin
        r = ub >> sh; o = r[31:0];
      end
      6'h03, 6'h07: begin
        r = sb >>> sh; o = r[31:0];
      end
`endif
      default: o = '0;
    endcase
    return {v, o};
  endfunction

  task automatic apply(string tag, logic rst,
                       logic [5:0] f, logic [31:0] a,
                       logic [31:0] b, logic [32:0] exp);
    logic [32:0] e;
    @(negedge clk);
    rst_n     = rst;
    bus.funct = f;
    bus.INa   = a;
    bus.INb   = b;
    #1;
    if (have_prev)
      check({tag, "_hold"},
            {bus.overflow, bus.OUT}, prev);
    q.push_back(exp);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check(tag, {bus.overflow, bus.OUT}, e);
    prev      = e;
    have_prev = 1'b1;
  endtask

  logic [5:0] codes[18] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h04,
    6'h02, 6'h06, 6'h03, 6'h07, 6'h3F, 6'h01
  };

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rf;
    logic [32:0] sra_e;
    logic [32:0] srl_e;
    logic [32:0] sh0_e;
    total     = 0;
    bad       = 0;
    have_prev = 1'b0;
    rst_n     = 1'b0;
    bus.funct = 6'h20;
    bus.INa   = '1;
    bus.INb   = '1;
`ifdef ALU_SHIFT_EN
    sra_e = {1'b0, 32'hF800_0000};
    srl_e = {1'b0, 32'h0800_0000};
    sh0_e = {1'b0, 32'h0000_1234};
`else
    sra_e = '0;
    srl_e = '0;
    sh0_e = '0;
`endif
    apply("rst0", 0, 6'h20, '1, '1, '0);
    apply("rst1", 0, 6'h20, '1, '1, '0);
    apply("rel", 1, 6'h20, '1, '1,
          {1'b0, 32'hFFFF_FFFE});
    apply("add_ov", 1, 6'h20, 32'h7FFF_FFFF,
          32'h1, {1'b1, 32'h8000_0000});
    apply("addu", 1, 6'h21, 32'h7FFF_FFFF,
          32'h1, {1'b0, 32'h8000_0000});
    apply("sub_ov", 1, 6'h22, 32'h8000_0000,
          32'h1, {1'b1, 32'h7FFF_FFFF});
    apply("sub", 1, 6'h22, 32'd5, 32'd7,
          {1'b0, 32'hFFFF_FFFE});
    apply("subu", 1, 6'h23, 32'h8000_0000,
          32'h1, {1'b0, 32'h7FFF_FFFF});
    apply("slt", 1, 6'h2A, 32'hFFFF_FFFF,
          32'h1, {1'b0, 32'h1});
    apply("sltu", 1, 6'h2B, 32'hFFFF_FFFF,
          32'h1, {1'b0, 32'h0});
    apply("sltu2", 1, 6'h2B, 32'h1,
          32'hFFFF_FFFF, {1'b0, 32'h1});
    apply("and", 1, 6'h24, 32'hF0F0_1234,
          32'hFF00_FF0F, {1'b0, 32'hF000_1204});
    apply("or", 1, 6'h25, 32'hF0F0_0000,
          32'h0F00_000F, {1'b0, 32'hFFF0_000F});
    apply("xor", 1, 6'h26, 32'hFFFF_0000,
          32'hF0F0_F0F0, {1'b0, 32'h0F0F_F0F0});
    apply("nor", 1, 6'h27, 32'h0F0F_0F0F,
          32'h00FF_00FF, {1'b0, 32'hF000_F000});
    apply("sra", 1, 6'h03, 32'd4,
          32'h8000_0000, sra_e);
    apply("srl", 1, 6'h02, 32'd4,
          32'h8000_0000, srl_e);
    apply("sll_sh0", 1, 6'h04, 32'hFFFF_FFE0,
          32'h1234, sh0_e);
    apply("lat_a", 1, 6'h20, 32'd1, 32'd2,
          {1'b0, 32'd3});
    apply("lat_b", 1, 6'h20, 32'd1, 32'd2,
          {1'b0, 32'd3});
    apply("lat_ill", 1, 6'h3F, 32'd1, 32'd2,
          '0);
    apply("ill_ov", 1, 6'h20, 32'h8000_0000,
          32'h8000_0000, {1'b1, 32'h0});
    apply("ill_clr", 1, 6'h3F, 32'h8000_0000,
          32'h8000_0000, '0);
    for (int i = 0; i < 48; i++) begin
      rf = codes[$urandom_range(17, 0)];
      ra = $urandom();
      rb = $urandom();
      if (i % 4 == 0) ra[31] = rb[31];
      apply("rnd", 1, rf, ra, rb,
            model(rf, ra, rb));
    end
    apply("rst_mid", 0, 6'h20, 32'h7FFF_FFFF,
          32'h1, '0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
